// File: rtl/word_sequencer_1553.sv
// word_sequencer_1553: plays a list of 1553 words from an internal word memory
// into a Manchester encoder. Each word goes out with a one-cycle sync strobe,
// then the encoder's busy handshake, then an idle gap.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data host write port; entry = {csw, dw, dword[15:0]}
//   start/abort           run request (IDLE only) / stop at next word boundary
//   base_addr/run_len     first entry and words per pass (0 = no words)
//   loop                  repeat the pass until abort
//   enc_busy              encoder tx_busy
//   tx_dword/tx_csw/tx_dw word and sync strobes to the encoder
//   active/done/tmo_err   run status, end-of-run pulse, sticky ack timeout
//   words_sent            saturating count of words taken by the encoder
//
// Build option: define WORD_SEQ_LOOP_EN to honour the loop input; without it
// every run is a single pass and loop is ignored.

module word_sequencer_1553 #(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned GAP_CYC = 16,
    parameter int unsigned ACK_TMO = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [17:0]                wr_data,
    input  logic                       start,
    input  logic                       abort,
    input  logic [$clog2(DEPTH)-1:0]   base_addr,
    input  logic [$clog2(DEPTH):0]     run_len,
    input  logic                       loop,
    input  logic                       enc_busy,
    output logic [15:0]                tx_dword,
    output logic                       tx_csw,
    output logic                       tx_dw,
    output logic                       active,
    output logic                       done,
    output logic                       tmo_err,
    output logic [15:0]                words_sent
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned ACK_W = $clog2(ACK_TMO + 1);
    localparam int unsigned CW    = (ACK_W > 8) ? ACK_W : 8;

    typedef struct packed {
        logic        csw;
        logic        dw;
        logic [15:0] dword;
    } entry_t;

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, ACK, XMIT, GAP} state_t;

    state_t         state, state_nx;
    logic [AW-1:0]  addr, addr_nx;
    logic [AW-1:0]  base_q, base_nx;
    logic [LW-1:0]  len_q, len_nx;
    logic [LW-1:0]  left, left_nx, left_dec;
    logic           loop_q, loop_nx;
    logic           abort_seen, abort_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [15:0]    tx_dword_nx;
    logic           tx_csw_nx, tx_dw_nx, done_nx, tmo_nx;
    logic [15:0]    words_nx;
    logic           loop_en;

    entry_t         mem [DEPTH];
    entry_t         rd_data;

`ifdef WORD_SEQ_LOOP_EN
    assign loop_en = loop;
`else
    logic loop_unused;
    assign loop_en     = 1'b0;
    assign loop_unused = loop;
`endif

    assign left_dec = left - LW'(1);

    // Word memory: synchronous read in FETCH; a same-cycle write returns old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= entry_t'(wr_data);
        end
        if (state == FETCH) begin
            rd_data <= mem[addr];
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            base_q     <= '0;
            len_q      <= '0;
            left       <= '0;
            loop_q     <= 1'b0;
            abort_seen <= 1'b0;
            cnt        <= '0;
            tx_dword   <= '0;
            tx_csw     <= 1'b0;
            tx_dw      <= 1'b0;
            active     <= 1'b0;
            done       <= 1'b0;
            tmo_err    <= 1'b0;
            words_sent <= '0;
        end else begin
            state      <= state_nx;
            addr       <= addr_nx;
            base_q     <= base_nx;
            len_q      <= len_nx;
            left       <= left_nx;
            loop_q     <= loop_nx;
            abort_seen <= abort_nx;
            cnt        <= cnt_nx;
            tx_dword   <= tx_dword_nx;
            tx_csw     <= tx_csw_nx;
            tx_dw      <= tx_dw_nx;
            active     <= (state_nx != IDLE);
            done       <= done_nx;
            tmo_err    <= tmo_nx;
            words_sent <= words_nx;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx    = state;
        addr_nx     = addr;
        base_nx     = base_q;
        len_nx      = len_q;
        left_nx     = left;
        loop_nx     = loop_q;
        abort_nx    = abort_seen | (abort && (state != IDLE));
        cnt_nx      = cnt;
        tx_dword_nx = tx_dword;
        tx_csw_nx   = 1'b0;
        tx_dw_nx    = 1'b0;
        done_nx     = 1'b0;
        tmo_nx      = tmo_err;
        words_nx    = words_sent;

        case (state)
            IDLE: begin
                abort_nx = 1'b0;
                if (start) begin
                    base_nx  = base_addr;
                    len_nx   = run_len;
                    loop_nx  = loop_en;
                    addr_nx  = base_addr;
                    left_nx  = run_len;
                    words_nx = '0;
                    tmo_nx   = 1'b0;
                    if (run_len != '0) begin
                        state_nx = FETCH;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            FETCH: begin
                cnt_nx   = '0;
                state_nx = ISSUE;
            end
            ISSUE: begin
                cnt_nx = '0;
                // csw wins over dw; an entry with neither bit is skipped silently.
                if (rd_data.csw || rd_data.dw) begin
                    tx_dword_nx = rd_data.dword;
                    tx_csw_nx   = rd_data.csw;
                    tx_dw_nx    = rd_data.dw & ~rd_data.csw;
                    state_nx    = ACK;
                end else begin
                    state_nx = GAP;
                end
            end
            ACK: begin
                if (enc_busy) begin
                    state_nx = XMIT;
                    if (words_sent != 16'hFFFF) begin
                        words_nx = words_sent + 16'd1;
                    end
                end else if (cnt == CW'(ACK_TMO - 1)) begin
                    tmo_nx      = 1'b1;
                    done_nx     = 1'b1;
                    tx_dword_nx = '0;
                    state_nx    = IDLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            XMIT: begin
                if (!enc_busy) begin
                    tx_dword_nx = '0;
                    cnt_nx      = '0;
                    state_nx    = GAP;
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYC - 1)) begin
                    if (abort_nx) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else if (left_dec != '0) begin
                        addr_nx  = addr + AW'(1);
                        left_nx  = left_dec;
                        abort_nx = 1'b0;
                        state_nx = FETCH;
                    end else if (loop_q) begin
                        addr_nx  = base_q;
                        left_nx  = len_q;
                        abort_nx = 1'b0;
                        state_nx = FETCH;
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_word_sequencer_1553.sv
// Directed bench for word_sequencer_1553 with a behavioural encoder model
// (busy rises 2 cycles after a strobe and stays up 40 cycles).

module tb_word_sequencer_1553;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [17:0]   wr_data = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   run_len = '0;
    logic          loop = 1'b0;
    logic          enc_busy = 1'b0;
    logic [15:0]   tx_dword;
    logic          tx_csw, tx_dw, active, done, tmo_err;
    logic [15:0]   words_sent;

    word_sequencer_1553 #(.DEPTH(DEPTH), .GAP_CYC(16), .ACK_TMO(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .abort(abort), .base_addr(base_addr), .run_len(run_len),
        .loop(loop), .enc_busy(enc_busy), .tx_dword(tx_dword), .tx_csw(tx_csw),
        .tx_dw(tx_dw), .active(active), .done(done), .tmo_err(tmo_err),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Strobe / done monitor, sampled mid-cycle.
    int          cyc = 0;
    int          n_strobe = 0;
    int          n_done = 0;
    int          last_done_cyc = 0;
    logic [17:0] slog [64];
    int          scyc [64];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if ((tx_csw || tx_dw) && n_strobe < 64) begin
            slog[n_strobe] = {tx_csw, tx_dw, tx_dword};
            scyc[n_strobe] = cyc;
            n_strobe = n_strobe + 1;
        end
        if (done) begin
            n_done = n_done + 1;
            last_done_cyc = cyc;
        end
    end

    // Encoder model: mode 0 holds busy low, mode 1 answers every strobe.
    int enc_mode = 1;
    int lag = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (enc_mode == 0) begin
            enc_busy = 1'b0;
            lag = 0;
            busy_cnt = 0;
        end else if (busy_cnt != 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) enc_busy = 1'b0;
        end else if (lag != 0) begin
            lag = lag - 1;
            if (lag == 0) begin
                enc_busy = 1'b1;
                busy_cnt = 40;
            end
        end else if (tx_csw || tx_dw) begin
            lag = 2;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [17:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l, input logic lp);
        base_addr = b; run_len = l; loop = lp; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(n_done >= target), 32'd1);
    endtask

    task automatic wait_strobes(input string tag, input int target, input int budget);
        int k = 0;
        while (n_strobe < target && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(n_strobe >= target), 32'd1);
    endtask

    int s0, d0;

    initial begin
        // Reset state
        steps(3);
        check("rst_dword", 32'(tx_dword), 32'd0);
        check("rst_strobes", 32'({tx_csw, tx_dw}), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_done_tmo", 32'({done, tmo_err}), 32'd0);
        check("rst_words", 32'(words_sent), 32'd0);
        reset = 1'b0;
        step();

        // Three-word list; abort in IDLE beforehand must be harmless
        wr(4'd0, 18'h25555);
        wr(4'd1, 18'h1ABCD);
        wr(4'd2, 18'h11234);
        abort = 1'b1; step(); abort = 1'b0; step();
        check("idle_abort_active", 32'(active), 32'd0);
        s0 = n_strobe; d0 = n_done;
        do_start(4'd0, 5'd3, 1'b0);
        check("t1_active", 32'(active), 32'd1);
        wait_done("t1_done_wait", d0 + 1, 600);
        steps(5);
        check("t1_nstrobe", 32'(n_strobe - s0), 32'd3);
        check("t1_w0", 32'(slog[s0]), 32'h25555);
        check("t1_w1", 32'(slog[s0+1]), 32'h1ABCD);
        check("t1_w2", 32'(slog[s0+2]), 32'h11234);
        check("t1_spacing01", 32'(scyc[s0+1] - scyc[s0]), 32'd61);
        check("t1_spacing12", 32'(scyc[s0+2] - scyc[s0+1]), 32'd61);
        check("t1_done_lat", 32'(last_done_cyc - scyc[s0+2]), 32'd59);
        check("t1_done_once", 32'(n_done - d0), 32'd1);
        check("t1_words", 32'(words_sent), 32'd3);
        check("t1_idle", 32'({active, tmo_err, tx_dword}), 32'd0);

        // Address wrap: DEPTH-1 then 0
        wr(4'd15, 18'h1F00F);
        s0 = n_strobe; d0 = n_done;
        do_start(4'd15, 5'd2, 1'b0);
        wait_done("t2_done_wait", d0 + 1, 400);
        check("t2_nstrobe", 32'(n_strobe - s0), 32'd2);
        check("t2_w0", 32'(slog[s0]), 32'h1F00F);
        check("t2_w1", 32'(slog[s0+1]), 32'h25555);
        check("t2_words", 32'(words_sent), 32'd2);

        // Encoder never acknowledges
        enc_mode = 0;
        wr(4'd3, 18'h23333);
        s0 = n_strobe; d0 = n_done;
        do_start(4'd3, 5'd2, 1'b0);
        wait_done("t3_done_wait", d0 + 1, 100);
        steps(3);
        check("t3_nstrobe", 32'(n_strobe - s0), 32'd1);
        check("t3_done_lat", 32'(last_done_cyc - scyc[s0]), 32'd4);
        check("t3_tmo", 32'(tmo_err), 32'd1);
        check("t3_words", 32'(words_sent), 32'd0);
        check("t3_active", 32'(active), 32'd0);
        enc_mode = 1;
        step();

        // Empty entry in the middle is skipped
        wr(4'd8, 18'h21111);
        wr(4'd9, 18'h0FFFF);
        wr(4'd10, 18'h12222);
        s0 = n_strobe; d0 = n_done;
        do_start(4'd8, 5'd3, 1'b0);
        check("t4_tmo_cleared", 32'(tmo_err), 32'd0);
        wait_done("t4_done_wait", d0 + 1, 600);
        check("t4_nstrobe", 32'(n_strobe - s0), 32'd2);
        check("t4_w1", 32'(slog[s0+1]), 32'h12222);
        check("t4_spacing", 32'(scyc[s0+1] - scyc[s0]), 32'd79);
        check("t4_words", 32'(words_sent), 32'd2);

        // run_len = 0: done one cycle after start, nothing sent
        s0 = n_strobe; d0 = n_done;
        do_start(4'd0, 5'd0, 1'b0);
        check("t5_done_now", 32'({done, active}), 32'b10);
        step();
        check("t5_done_gone", 32'(done), 32'd0);
        steps(5);
        check("t5_nstrobe", 32'(n_strobe - s0), 32'd0);
        check("t5_done_once", 32'(n_done - d0), 32'd1);

        // Write hitting the address being fetched returns the old entry
        wr(4'd6, 18'h26666);
        s0 = n_strobe; d0 = n_done;
        do_start(4'd6, 5'd1, 1'b0);
        wr(4'd6, 18'h27777);
        wait_done("t6_done_wait", d0 + 1, 200);
        check("t6_old", 32'(slog[s0]), 32'h26666);
        s0 = n_strobe; d0 = n_done;
        do_start(4'd6, 5'd1, 1'b0);
        wait_done("t6b_done_wait", d0 + 1, 200);
        check("t6_new", 32'(slog[s0]), 32'h27777);

        // Looping pass with abort during the 5th word
        wr(4'd4, 18'h1AAAA);
        wr(4'd5, 18'h1BBBB);
        s0 = n_strobe; d0 = n_done;
        do_start(4'd4, 5'd2, 1'b1);
`ifdef WORD_SEQ_LOOP_EN
        wait_strobes("t7_strobe_wait", s0 + 5, 600);
        steps(10);
        abort = 1'b1; step(); abort = 1'b0;
        wait_done("t7_done_wait", d0 + 1, 200);
        steps(3);
        check("t7_nstrobe", 32'(n_strobe - s0), 32'd5);
        check("t7_w4", 32'(slog[s0+4]), 32'h1AAAA);
        check("t7_done_lat", 32'(last_done_cyc - scyc[s0+4]), 32'd59);
        check("t7_words", 32'(words_sent), 32'd5);
`else
        wait_done("t7_done_wait", d0 + 1, 400);
        steps(3);
        check("t7_nstrobe", 32'(n_strobe - s0), 32'd2);
        check("t7_words", 32'(words_sent), 32'd2);
`endif

        // Reset while the encoder is transmitting
        s0 = n_strobe; d0 = n_done;
        do_start(4'd0, 5'd1, 1'b0);
        wait_strobes("t8_strobe_wait", s0 + 1, 50);
        steps(10);
        check("t8_in_xmit", 32'({active, tx_dword}), 32'h15555);
        reset = 1'b1; enc_mode = 0;
        step();
        check("t8_rst_outs", 32'({tx_csw, tx_dw, active, done, tmo_err, tx_dword}), 32'd0);
        check("t8_rst_words", 32'(words_sent), 32'd0);
        reset = 1'b0;
        steps(3);
        check("t8_no_done", 32'(n_done - d0), 32'd0);
        enc_mode = 1;
        step();
        s0 = n_strobe; d0 = n_done;
        do_start(4'd0, 5'd1, 1'b0);
        wait_done("t8_done_wait", d0 + 1, 200);
        check("t8_w0", 32'(slog[s0]), 32'h25555);
        check("t8_words", 32'(words_sent), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/word_sequencer_1553.md
WORD_SEQUENCER_1553 -- requirements
Module: word_sequencer_1553

Interface
REQ-001 SHALL have parameter DEPTH, default 512, word-memory entries (power of two, 2..4096).
REQ-002 SHALL have parameter GAP_CYC, default 16, idle clk cycles inserted between words (1..255).
REQ-003 SHALL have parameter ACK_TMO, default 4, max cycles from strobe to encoder busy rise.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  memory write strobe.
REQ-007 SHALL have port wr_addr  input  clog2(DEPTH)  memory write address.
REQ-008 SHALL have port wr_data  input  18  {csw, dw, dword[15:0]} entry.
REQ-009 SHALL have port start  input  1  one-cycle run request.
REQ-010 SHALL have port abort  input  1  stop the run at the next word boundary.
REQ-011 SHALL have port base_addr  input  clog2(DEPTH)  first entry of the run.
REQ-012 SHALL have port run_len  input  clog2(DEPTH)+1  number of words per pass (0 = no words).
REQ-013 SHALL have port loop  input  1  repeat the pass until abort.
REQ-014 SHALL have port enc_busy  input  1  encoder tx_busy.
REQ-015 SHALL have port tx_dword  output  16  word to encoder.
REQ-016 SHALL have port tx_csw  output  1  command/status sync strobe.
REQ-017 SHALL have port tx_dw  output  1  data sync strobe.
REQ-018 SHALL have port active  output  1  run in progress.
REQ-019 SHALL have port done  output  1  one-cycle end-of-run pulse.
REQ-020 SHALL have port tmo_err  output  1  sticky encoder-acknowledge timeout.
REQ-021 SHALL have port words_sent  output  16  saturating count of words accepted by the encoder.

Function
REQ-022 SHALL implement FSM states IDLE, FETCH, ISSUE, ACK, XMIT, GAP.
REQ-023 SHALL accept start only in IDLE; in other states start is ignored; it latches base_addr, run_len and loop and clears words_sent and tmo_err.
REQ-024 SHALL go IDLE->FETCH on start with run_len>0; on run_len=0 it stays IDLE and pulses done the next cycle.
REQ-025 SHALL use synchronous-read memory: FETCH holds one cycle, then ISSUE.
REQ-026 SHALL drive tx_dword with the entry in ISSUE, and SHALL drive tx_csw/tx_dw from entry bits 17/16 for exactly one cycle.
REQ-027 SHALL treat an entry with both csw and dw set as a csw word (tx_dw=0), and SHALL skip an entry with neither bit set (no strobe, no count, straight to GAP).
REQ-028 SHALL hold tx_dword stable from ISSUE until XMIT exits, and SHALL drive it 0 otherwise.
REQ-029 SHALL wait in ACK for enc_busy=1, counting up to ACK_TMO cycles; on rise it SHALL go to XMIT and increment words_sent (saturating at 0xFFFF).
REQ-030 SHALL respond to ACK timeout by setting tmo_err, pulsing done, and returning to IDLE.
REQ-031 SHALL leave XMIT on enc_busy=0 and go to GAP, and SHALL count GAP_CYC cycles in GAP.
REQ-032 SHALL act at GAP end as follows: if abort was seen since ISSUE -> IDLE + done; else if words remain -> FETCH at addr+1; else if loop -> FETCH at base_addr; else -> IDLE + done.
REQ-033 SHALL wrap the address modulo DEPTH (base_addr+run_len may exceed DEPTH).
REQ-034 SHALL never truncate an in-flight word on abort; abort asserted in IDLE has no effect.
REQ-035 SHALL let a memory write hit the currently fetched address; the value read SHALL be the old data (read-before-write).
REQ-036 SHALL drive active=1 in every state except IDLE.

Reset
REQ-037 SHALL on reset enter IDLE with tx_dword=0, tx_csw=0, tx_dw=0, active=0, done=0, tmo_err=0, words_sent=0 and all counters cleared, regardless of the current state.
REQ-038 SHALL leave memory contents unchanged on reset.
REQ-039 SHALL not pulse done when a reset interrupts a run.

Configuration
REQ-040 SHALL support macro WORD_SEQ_LOOP_EN: when defined, loop behaves per REQ-032.
REQ-041 SHALL, when WORD_SEQ_LOOP_EN is undefined, keep the loop port but ignore it (single pass only), with all other behaviour identical.

Verification
REQ-042 SHALL cover: entries 0..2 = {csw,5555},{dw,ABCD},{dw,1234}, base=0, len=3, encoder model busy 40 cycles after 2-cycle lag -> three strobes in order, 16-cycle gaps, words_sent=3, done once.
REQ-043 SHALL cover: base=DEPTH-1, len=2 -> entries DEPTH-1 then 0 sent.
REQ-044 SHALL cover: enc_busy tied 0 -> tmo_err=1 and done 4 cycles after the strobe, words_sent=0.
REQ-045 SHALL cover: WORD_SEQ_LOOP_EN defined, loop=1, len=2, abort during the 5th word -> 5 words sent, done after the 5th gap; with the macro undefined -> 2 words sent.
REQ-046 SHALL cover: an entry with both bits 0 mid-list -> no strobe for it and words_sent excludes it; run_len=0 -> done 1 cycle after start, no strobe.
REQ-047 SHALL cover: reset asserted in XMIT -> all outputs at reset values next cycle, no done pulse, and a new start runs normally.
